sum_accum: RTL



---
 rtl/sum_accum.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sum_accum.sv
// Purpose: accumulate a frame of L unsigned adder sums into one wide total plus beat count.
// Latency: result valid the cycle after the frame's last beat is accepted; one beat/cycle.
// Backpressure: while a result is unclaimed, in_ready follows out_ready (zero-bubble turnover).
module sum_accum #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 8,
    parameter int ACC_W = WIDTH + LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LEN_W-1:0] frame_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [LEN_W:0]   out_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // frame_len == 0 encodes the maximum frame of 2^LEN_W beats
    localparam logic [LEN_W:0] FULL_LEN = {1'b1, {LEN_W{1'b0}}};
    localparam logic [LEN_W:0] ONE_CNT  = {{LEN_W{1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [LEN_W:0]     r_cnt;
    logic [LEN_W:0]     r_len;
    logic [ACC_W-1:0]   r_out_data;
    logic [LEN_W:0]     r_out_count;

    logic               w_accept;
    logic               w_start;
    logic               w_done;
    logic [LEN_W:0]     w_len_dec;
    logic [LEN_W:0]     w_len_eff;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [LEN_W:0]     w_cnt_nxt;

    assign out_valid = (r_state == HOLD);
    assign out_data  = r_out_data;
    assign out_count = r_out_count;

    // Handshake, frame-start detection and next accumulator/counter values
    always_comb begin
        in_ready  = (r_state == HOLD) ? out_ready : 1'b1;
        w_accept  = in_valid && in_ready;
        // A beat accepted in IDLE, or in HOLD while the result is taken, opens a new frame
        w_start   = w_accept && (r_state != ACCUM);
        w_len_dec = (frame_len == '0) ? FULL_LEN : {1'b0, frame_len};
        w_len_eff = w_start ? w_len_dec : r_len;
        w_acc_nxt = w_start ? ACC_W'(in_data) : (r_acc + ACC_W'(in_data));
        w_cnt_nxt = w_start ? ONE_CNT : (r_cnt + ONE_CNT);
        w_done    = w_accept && (w_cnt_nxt == w_len_eff);
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_done ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (w_done) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (w_accept) begin
                        w_state_nxt = w_done ? HOLD : ACCUM;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accumulator, beat counter and latched frame length update on every accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_len <= '0;
        end else if (w_accept) begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_start) begin
                r_len <= w_len_dec;
            end
        end
    end

    // Result registers load only on the frame's last beat so they stay stable until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_count <= '0;
        end else if (w_done) begin
            r_out_data  <= w_acc_nxt;
            r_out_count <= w_cnt_nxt;
        end
    end

endmodule
